led_sequencer: RTL
==================

LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, meaning xclk cycles per sequencer tick (>=2).
REQ-002 SHALL have parameter N_ENTRIES, default 8, meaning pattern table depth (fixed at 8 in this revision).
REQ-003 SHALL have port xclk  input  1  system clock; the only clock.
REQ-004 SHALL have port sys_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port wr_en  input  1  single-cycle register write strobe.
REQ-006 SHALL have port wr_addr  input  4  register address: 0-7 table entries, 8 control.
REQ-007 SHALL have port wr_data  input  8  register write data.
REQ-008 SHALL have port red_flash  input  1  red flasher phase.
REQ-009 SHALL have port green_flash  input  1  green flasher phase.
REQ-010 SHALL have port led_r  output  1  red LED drive.
REQ-011 SHALL have port led_g  output  1  green LED drive.
REQ-012 SHALL have port seq_active  output  1  high while in RUN.
REQ-013 SHALL have port seq_step  output  3  index of the current entry.
REQ-014 SHALL have port seq_done  output  1  one-cycle pulse at natural sequence end.

Function
REQ-015 Table entry SHALL be mode[7:6] (00 off, 01 alternating, 10 sync, 11 both on) and duration[5:0] in ticks; duration 0 marks end of table.
REQ-016 Control register SHALL decode bit0 start, bit1 loop (stored), bit2 stop (strobe only); start/stop are not stored.
REQ-017 Writes to addresses 9-15 SHALL be ignored.
REQ-018 FSM states SHALL be IDLE, RUN, DONE.
REQ-019 Start write in cycle N SHALL enter RUN at N+1 with seq_step=0, entry 0 loaded, prescaler cleared; if entry 0 duration is 0, go to DONE instead.
REQ-020 Prescaler SHALL count 0..TICK_DIV-1 in RUN and assert tick for one cycle at TICK_DIV-1; the count is held at 0 outside RUN.
REQ-021 On entry load, dur_cnt SHALL take the entry duration; each tick decrements it; a tick at dur_cnt==1 advances, so an entry lasts exactly duration*TICK_DIV cycles.
REQ-022 Advance SHALL go to step+1 unless step==7 or that next entry's duration is 0, in which case it is the end.
REQ-023 At end with loop=1, SHALL reload step 0 in the same cycle with no gap; with loop=0, SHALL enter DONE.
REQ-024 DONE SHALL last one cycle with seq_done=1, then go to IDLE.
REQ-025 led_r/led_g SHALL be combinational from the registered current mode: off 0/0, alternating red_flash/green_flash, sync red_flash/red_flash, both-on 1/1; 0/0 in IDLE and DONE.
REQ-026 Stop write SHALL go to IDLE the next cycle, LEDs 0, with no seq_done.
REQ-027 Start and stop in the same write SHALL act as stop.
REQ-028 Start during RUN SHALL restart at step 0 per REQ-019.
REQ-029 A table write during RUN SHALL take effect only when that entry is next loaded; it SHALL never modify the active dur_cnt.
REQ-030 Clearing the loop bit during RUN SHALL apply at the next end-of-table decision.

Reset
REQ-031 sys_rst SHALL set state IDLE, all table entries 0, loop 0, seq_step 0, dur_cnt 0, prescaler 0, and led_r, led_g, seq_active, seq_done all 0.
REQ-032 Reset mid-RUN SHALL abort the sequence without a seq_done pulse.

Structure
REQ-033 The shared defines file SHALL hold the mode encodings, the address map (table base 0, control 8) and the control bit positions.
REQ-034 The tick prescaler SHALL be a sub-module led_seq_tick with ports xclk, sys_rst, clr, tick.

Verification (TICK_DIV=4)
REQ-035 Entry0=0x42, entry1=0x81, entry2=0x00; start -> alternating for 8 cycles, then sync for 4 cycles, then seq_done pulse; seq_step goes 0,1.
REQ-036 Same table with loop=1 (control write 0x03) -> step returns 1->0 with no idle cycle; seq_done stays 0 across 3 loops.
REQ-037 Stop at cycle 5 of entry0 -> IDLE next cycle, LEDs 0/0, no seq_done.
REQ-038 Entry0=0x00; start -> seq_done pulses at N+1; seq_active never rises.
REQ-039 All 8 entries=0xC1 -> steps 0..7, each 4 cycles with both LEDs on, then seq_done (step-7 wrap end).
REQ-040 Assert sys_rst mid-RUN and write control 0x05 -> after reset all outputs 0; the 0x05 write leaves the block IDLE.

Source files
------------

// File: rtl/led_sequencer_pkg.sv
// Shared encodings for the LED sequencer: entry modes, FSM states,
// register address map and control-register bit positions.
package led_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_ALT  = 2'b01,
    MODE_SYNC = 2'b10,
    MODE_ON   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] ADDR_TABLE_BASE = 4'd0;
  localparam logic [3:0] ADDR_CTRL       = 4'd8;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_LOOP_BIT  = 1;
  localparam int CTRL_STOP_BIT  = 2;

  localparam int DUR_W  = 6;
  localparam int STEP_W = 3;

  function automatic logic [DUR_W-1:0] entry_dur(input logic [7:0] entry);
    return entry[DUR_W-1:0];
  endfunction

  function automatic mode_e entry_mode(input logic [7:0] entry);
    return mode_e'(entry[7:6]);
  endfunction

endpackage

// File: rtl/led_seq_tick.sv
// Tick prescaler: free-runs 0..TICK_DIV-1 while clr is low and flags the
// last count; clr forces and holds the count at zero.
module led_seq_tick #(
  parameter int TICK_DIV = 1000000
) (
  input  logic xclk,
  input  logic sys_rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge xclk) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_sequencer.sv
// Table-driven red/green LED sequencer: steps through up to eight
// mode/duration entries per tick, optionally looping, with start/stop control.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int TICK_DIV  = 1000000,
  parameter int N_ENTRIES = 8
) (
  input  logic       xclk,
  input  logic       sys_rst,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       red_flash,
  input  logic       green_flash,
  output logic       led_r,
  output logic       led_g,
  output logic       seq_active,
  output logic [2:0] seq_step,
  output logic       seq_done
);

  logic [7:0]        pat_q [N_ENTRIES];
  logic [7:0]        pat_d [N_ENTRIES];
  logic              loop_q, loop_d;
  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  mode_e             mode_q, mode_d;
  logic [DUR_W-1:0]  dur_q, dur_d;

  logic              tbl_wr;
  logic              ctrl_wr;
  logic              start_cmd;
  logic              stop_cmd;
  logic              tick;
  logic              presc_clr;
  logic              restart;
  logic              advance;
  logic              last_entry;
  logic [STEP_W-1:0] nxt_step;
  logic [7:0]        nxt_entry;
  logic [7:0]        first_entry;

  // Register decode; stop wins over start when both are set in one write.
  assign tbl_wr    = wr_en && (wr_addr < ADDR_CTRL);
  assign ctrl_wr   = wr_en && (wr_addr == ADDR_CTRL);
  assign start_cmd = ctrl_wr && wr_data[CTRL_START_BIT] && !wr_data[CTRL_STOP_BIT];
  assign stop_cmd  = ctrl_wr && wr_data[CTRL_STOP_BIT];

  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      pat_d[i] = pat_q[i];
    end
    if (tbl_wr) begin
      pat_d[wr_addr[2:0] - ADDR_TABLE_BASE[2:0]] = wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_ENTRIES; gi++) begin : g_pat
      always_ff @(posedge xclk) begin
        if (sys_rst) begin
          pat_q[gi] <= '0;
        end else begin
          pat_q[gi] <= pat_d[gi];
        end
      end
    end
  endgenerate

  assign loop_d = ctrl_wr ? wr_data[CTRL_LOOP_BIT] : loop_q;

  assign nxt_step    = step_q + 1'b1;
  assign nxt_entry   = pat_q[nxt_step];
  assign first_entry = pat_q[0];
  assign last_entry  = (step_q == STEP_W'(7)) || (entry_dur(nxt_entry) == '0);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    mode_d  = mode_q;
    dur_d   = dur_q;
    restart = 1'b0;
    advance = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_cmd) restart = 1'b1;
      end
      ST_RUN: begin
        if (start_cmd) begin
          restart = 1'b1;
        end else if (tick) begin
          if (dur_q == DUR_W'(1)) begin
            if (!last_entry) begin
              advance = 1'b1;
            end else if (loop_q) begin
              restart = 1'b1;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            dur_d = dur_q - 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (start_cmd) restart = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // An empty entry 0 ends the sequence immediately instead of running.
    if (restart) begin
      step_d  = '0;
      mode_d  = entry_mode(first_entry);
      dur_d   = entry_dur(first_entry);
      state_d = (entry_dur(first_entry) == '0) ? ST_DONE : ST_RUN;
    end else if (advance) begin
      step_d = nxt_step;
      mode_d = entry_mode(nxt_entry);
      dur_d  = entry_dur(nxt_entry);
    end

    if (stop_cmd) begin
      state_d = ST_IDLE;
      step_d  = '0;
      mode_d  = MODE_OFF;
      dur_d   = '0;
    end
  end

  always_ff @(posedge xclk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      loop_q  <= 1'b0;
      step_q  <= '0;
      mode_q  <= MODE_OFF;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      loop_q  <= loop_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
      dur_q   <= dur_d;
    end
  end

  // Prescaler restarts on every fresh load of entry 0 and idles outside RUN.
  assign presc_clr = (state_d != ST_RUN) || restart;

  led_seq_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .xclk   (xclk),
    .sys_rst(sys_rst),
    .clr    (presc_clr),
    .tick   (tick)
  );

  always_comb begin
    led_r = 1'b0;
    led_g = 1'b0;
    if (state_q == ST_RUN) begin
      unique case (mode_q)
        MODE_OFF:  begin led_r = 1'b0;      led_g = 1'b0;        end
        MODE_ALT:  begin led_r = red_flash; led_g = green_flash; end
        MODE_SYNC: begin led_r = red_flash; led_g = red_flash;   end
        MODE_ON:   begin led_r = 1'b1;      led_g = 1'b1;        end
        default:   begin led_r = 1'b0;      led_g = 1'b0;        end
      endcase
    end
  end

  assign seq_active = (state_q == ST_RUN);
  assign seq_done   = (state_q == ST_DONE);
  assign seq_step   = step_q;

endmodule
